// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch front end with PC, imem handshake and prefetch FIFO
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t        state, state_n;
    logic [31:0]   pc, pc_n;
    logic [31:0]   mem_data [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   cnt, cnt_n;
    logic          push, pop, flush, hold_addr;

    assign instr_valid = (cnt != '0);
    assign instruction = mem_data[rd_ptr];
    assign instr_pc    = mem_pc[rd_ptr];

    // Next-state, next-PC and FIFO occupancy after this edge's push/pop/flush
    always_comb begin
        push      = (state == BUSY) && imem_ack && !redirect_valid;
        pop       = instr_valid && instr_ready;
        flush     = redirect_valid;
        cnt_n     = cnt;
        pc_n      = pc;
        state_n   = state;
        hold_addr = 1'b0;

        if (flush) begin
            cnt_n = '0;
        end else if (push && !pop) begin
            cnt_n = cnt + CNT_ONE;
        end else if (!push && pop) begin
            cnt_n = cnt - CNT_ONE;
        end

        // Word alignment is forced; the low redirect bits carry no meaning here.
        if (redirect_valid) begin
            pc_n = {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            pc_n = pc + 32'd4;
        end

        case (state)
            IDLE: begin
                if (redirect_valid || (cnt_n < CNT_FULL)) state_n = BUSY;
            end
            BUSY: begin
                if (redirect_valid) begin
                    // Without the ack in hand the old request must still be retired.
                    state_n   = imem_ack ? BUSY : DRAIN;
                    hold_addr = !imem_ack;
                end else if (imem_ack) begin
                    state_n = (cnt_n < CNT_FULL) ? BUSY : IDLE;
                end
            end
            DRAIN: begin
                state_n   = imem_ack ? BUSY : DRAIN;
                hold_addr = !imem_ack;
            end
            default: state_n = IDLE;
        endcase
    end

    // Fetch FSM with registered bus outputs; address frozen while draining a stale request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            imem_req <= (state_n != IDLE);
            if (!hold_addr) imem_addr <= pc_n;
        end
    end

    // Prefetch FIFO storage and pointers; flush wins over any push on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else begin
            cnt <= cnt_n;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    mem_data[wr_ptr] <= imem_rdata;
                    mem_pc[wr_ptr]   <= pc;
                    wr_ptr           <= wr_ptr + PTR_ONE;
                end
                if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int wait_n = 0;
    int wcnt   = 0;

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    // Memory model: ack after wait_n wait cycles, word derived from the address
    assign imem_ack   = imem_req && (wcnt == wait_n);
    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    // Wait-cycle counter for the memory model
    always @(posedge clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] exp_pc);
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
        chk({tag, "_pc"}, instr_pc, exp_pc);
        chk({tag, "_word"}, instruction, exp_pc ^ 32'hA5A5_0000);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        chk("rst_req",   {31'b0, imem_req}, 32'd0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_ipc",   instr_pc, 32'h0);

        // Zero-wait streaming, one instruction per cycle
        wait_n = 0;
        instr_ready = 1'b1;
        do_reset();
        step();
        chk("t1_req", {31'b0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr, 32'h0);
        chk("t1_bubble", {31'b0, instr_valid}, 32'd0);
        step();
        chk_head("t1_h0", 32'h0);
        for (int i = 1; i < 4; i++) begin
            step();
            chk_head("t1_hn", 32'(i * 4));
        end

        // Backpressure: FIFO fills to 4, fetch parks at 0x10, then resumes
        instr_ready = 1'b0;
        do_reset();
        repeat (5) step();
        repeat (10) step();
        chk("t2_req_idle", {31'b0, imem_req}, 32'd0);
        chk("t2_addr_idle", imem_addr, 32'h10);
        chk_head("t2_h0", 32'h0);
        instr_ready = 1'b1;
        step();
        chk_head("t2_h4", 32'h4);
        chk("t2_req_resume", {31'b0, imem_req}, 32'd1);
        chk("t2_addr_resume", imem_addr, 32'h10);
        step();
        chk_head("t2_h8", 32'h8);
        step();
        chk_head("t2_hc", 32'hC);
        step();
        chk_head("t2_h10", 32'h10);

        // Redirect during a 3-wait-cycle fetch: stale reply must be dropped
        wait_n = 3;
        instr_ready = 1'b1;
        do_reset();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        chk("t3_addr_hold", imem_addr, 32'h0);
        chk("t3_req_hold", {31'b0, imem_req}, 32'd1);
        chk("t3_no_valid", {31'b0, instr_valid}, 32'd0);
        step();
        chk("t3_addr_ack", imem_addr, 32'h0);
        for (int n = 0; n < 20; n++) begin
            step();
            if (instr_valid) break;
        end
        chk_head("t3_h100", 32'h100);

        // Redirect coinciding with the ack of pc 0x8
        wait_n = 0;
        instr_ready = 1'b0;
        do_reset();
        step();
        step();
        step();
        chk("t4_addr8", imem_addr, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        chk("t4_flushed", {31'b0, instr_valid}, 32'd0);
        chk("t4_addr200", imem_addr, 32'h200);
        chk("t4_req", {31'b0, imem_req}, 32'd1);
        step();
        chk_head("t4_h200", 32'h200);

        // Redirect near the top of memory (low bits ignored) and wrap to zero
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        chk("t5_flushed", {31'b0, instr_valid}, 32'd0);
        chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        chk_head("t5_htop", 32'hFFFF_FFFC);
        step();
        chk_head("t5_hwrap", 32'h0);

        // Asynchronous reset with a request outstanding and 3 words buffered
        instr_ready = 1'b0;
        do_reset();
        repeat (4) step();
        chk("t6_req_pre", {31'b0, imem_req}, 32'd1);
        chk_head("t6_h0_pre", 32'h0);
        rst = 1'b1;
        #1;
        chk("t6_req_async", {31'b0, imem_req}, 32'd0);
        chk("t6_valid_async", {31'b0, instr_valid}, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("t6_req_restart", {31'b0, imem_req}, 32'd1);
        chk("t6_addr_restart", imem_addr, 32'h0);
        chk("t6_valid_restart", {31'b0, instr_valid}, 32'd0);
        step();
        chk_head("t6_h0", 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end for the mini-MIPS core. Holds the program counter, fetches words from instruction memory over a req/ack handshake, and buffers them in a small prefetch FIFO. The FIFO head drives the core's `instruction` input. Branch/jump redirects from the core flush the buffer and restart fetch at the new PC.

## Interface
- `DEPTH`, 4: prefetch FIFO entries (power of two, ≥2).
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  byte address of the request; stable while `imem_req` is high.
- `imem_ack`  in  1  memory completion; sampled only while `imem_req` is high.
- `imem_rdata`  in  32  fetched word; valid in the `imem_ack` cycle.
- `redirect_valid`  in  1  core requests a PC change (taken branch/jump).
- `redirect_pc`  in  32  target address; word-aligned.
- `instr_valid`  out  1  FIFO head is valid.
- `instr_ready`  in  1  core accepts the head this cycle.
- `instruction`  out  32  FIFO head word.
- `instr_pc`  out  32  address the head word was fetched from.

## Operation
- Bus rules:
  - At most one request is outstanding.
  - Once raised, `imem_req` and `imem_addr` hold until the edge where `imem_ack` is sampled high.
  - Zero-wait memory is legal: `imem_ack` may be high in the first `imem_req` cycle.
- FSM states:
  - IDLE: `imem_req`=0.
  - BUSY: `imem_req`=1, `imem_addr`=pc.
  - DRAIN: `imem_req`=1, holding a stale address whose reply is discarded.
- `cnt_n` is the FIFO occupancy after this edge's push, pop and flush.
- IDLE transitions:
  - → BUSY when `cnt_n` < DEPTH.
  - On redirect: pc←`redirect_pc`, flush the FIFO, → BUSY.
- BUSY with ack and no redirect:
  - Push {`imem_rdata`, pc}; pc←pc+4, wrapping mod 2^32.
  - → BUSY at the new pc if `cnt_n` < DEPTH, else → IDLE.
- BUSY with ack and redirect on the same edge: discard the reply, flush, pc←`redirect_pc`, → BUSY.
- BUSY with redirect and no ack: flush, pc←`redirect_pc`, → DRAIN. `imem_addr` keeps the old address.
- DRAIN:
  - On ack: discard the reply, → BUSY at pc.
  - On a further redirect: pc←`redirect_pc`, stay in DRAIN.
  - On redirect and ack together: discard, pc←`redirect_pc`, → BUSY.
- FIFO:
  - `instr_valid` = !empty.
  - Pop when `instr_valid` && `instr_ready`.
  - Push and pop on the same edge are both honoured.
  - A request is issued only with a free slot reserved, so a push never overflows.
- Flush rules:
  - Flush empties the FIFO at the edge, after any same-edge pop.
  - A pop on the redirect cycle counts as consumed.
  - `instr_ready` is ignored while `instr_valid`=0.
- `redirect_pc[1:0]` are ignored (treated as 0).

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC, pc=RESET_PC, state IDLE.
  - FIFO empty, `instr_valid`=0, `instruction`=0, `instr_pc`=0.
- First edge after reset release: IDLE→BUSY; `imem_req` rises in the following cycle.
- Reset mid-transaction aborts immediately: `imem_req` drops asynchronously and no reply is consumed.
- Ack→`instr_valid` latency: a word acked at edge k is visible as the head from edge k.
- Throughput: with zero-wait memory and `instr_ready` held high, one instruction per cycle indefinitely.
- Redirect→first new instruction with zero-wait memory:
  - redirect edge k, request during cycle k..k+1, ack at k+1, `instr_valid` after k+1.
  - `instr_valid` is low for exactly one cycle after k.
- Backpressure:
  - With `instr_ready`=0, fetch stops once the FIFO holds DEPTH words; `imem_req` is then 0.
  - Fetch resumes in the cycle after the first pop.

## Test plan
- Reset, zero-wait memory returning word=addr^32'hA5A5_0000, `instr_ready`=1:
  - heads pc=0,4,8,C in consecutive cycles;
  - `instr_pc` matches each word;
  - no bubble after the first.
- `instr_ready`=0 for 10 cycles:
  - exactly 4 words buffered (pc 0..C);
  - `imem_req`=0 with `imem_addr`=0x10;
  - after `instr_ready`=1, words pop in order and fetch resumes at 0x10.
- Memory acks after 3 wait cycles, redirect to 0x100 on the 2nd wait cycle:
  - `imem_addr` stays at the old value until ack;
  - the stale word never appears at the head;
  - the next head has pc=0x100.
- Redirect to 0x200 on the same edge as an ack of pc 0x8:
  - word at 0x8 dropped;
  - FIFO flushed;
  - next head has pc=0x200.
- Start fetch at `redirect_pc`=0xFFFF_FFFC:
  - heads pc=0xFFFF_FFFC then 0x0000_0000 (wrap).
- Assert `rst` while `imem_req` is high and the FIFO holds 3 words:
  - `imem_req` and `instr_valid` drop immediately;
  - fetch restarts at RESET_PC after release.
